// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
//   Frame sequencer for the streaming FFT datapath. It accepts upstream samples
//   over a valid/ready handshake and drives the shared sample counter cnt that
//   every radix/reorder stage decodes. Frames run back-to-back with no idle
//   cycles. Underruns are zero-filled without stalling the frame. After the last
//   frame the counter keeps running long enough to drain the datapath. Frame
//   markers are re-timed to the datapath output through a LAT-deep token pipe.
//
// Parameters
//   CBW  log2 of the frame length N; also the width of cnt
//   LAT  datapath latency din->dout in clk cycles (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   upstream sample valid
//   in_ready   sample accepted when in_valid && in_ready
//   cnt        sample index on the datapath this cycle
//   dvalid     datapath sample is real (0 = zero-fill)
//   din_sel    1 = upstream data into datapath, 0 = force zero
//   out_valid  dvalid delayed by LAT
//   out_sof    frame start (cnt==0 of a real frame) delayed by LAT
//   out_last   frame end (cnt==N-1 of a real frame) delayed by LAT
//   busy       sequencer active or tokens still in flight
//   err        sticky underrun flag
//   err_clr    clears err (a same-cycle underrun wins)
//   err_cnt    [FFT_FRAME_CTRL_ERRCNT_EN only] saturating count of frames
//              containing at least one underrun
//
// Build option
//   FFT_FRAME_CTRL_ERRCNT_EN  adds the err_cnt output and its counter.

module fft_frame_ctrl #(
   parameter int unsigned CBW = 3,
   parameter int unsigned LAT = 12
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [CBW-1:0] cnt,
   output logic           dvalid,
   output logic           din_sel,
   output logic           out_valid,
   output logic           out_sof,
   output logic           out_last,
   output logic           busy,
   output logic           err,
   input  logic           err_clr
`ifdef FFT_FRAME_CTRL_ERRCNT_EN
   ,
   output logic [7:0]     err_cnt
`endif
);

   localparam int unsigned FW = $clog2(LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t         r_state, w_state_nxt;
   logic [CBW-1:0] r_cnt, w_cnt_nxt;
   logic [FW-1:0]  r_fcnt, w_fcnt_nxt;
   logic           r_err;
   logic           w_ready, w_dvalid, w_sof, w_last, w_under;
   logic [LAT-1:0] r_tv, r_ts, r_tl;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_fcnt_nxt  = (r_fcnt != '0) ? r_fcnt - 1'b1 : '0;
      w_ready     = 1'b0;
      w_dvalid    = 1'b0;
      w_sof       = 1'b0;
      w_last      = 1'b0;
      w_under     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready    = 1'b1;
            w_fcnt_nxt = '0;
            if (in_valid) begin
               w_dvalid    = 1'b1;
               w_sof       = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_cnt_nxt = '0;
            end
         end
         S_RUN: begin
            w_ready = 1'b1;
            if (r_cnt == '0) begin
               if (in_valid) begin
                  w_dvalid = 1'b1;
                  w_sof    = 1'b1;
               end else begin
                  w_state_nxt = S_FLUSH;
                  w_fcnt_nxt  = FW'(LAT);
               end
            end else begin
               // Underrun zero-fills the slot; the frame keeps its timing.
               w_dvalid = in_valid;
               w_under  = ~in_valid;
               w_last   = (r_cnt == '1);
            end
         end
         S_FLUSH: begin
            // New frames may only start on a frame boundary.
            if (r_cnt == '0) begin
               w_ready = 1'b1;
               if (in_valid) begin
                  w_dvalid    = 1'b1;
                  w_sof       = 1'b1;
                  w_state_nxt = S_RUN;
               end else if (r_fcnt == '0) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_fcnt  <= '0;
         r_err   <= 1'b0;
         r_tv    <= '0;
         r_ts    <= '0;
         r_tl    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_fcnt  <= w_fcnt_nxt;
         if (w_under)
            r_err <= 1'b1;
         else if (err_clr)
            r_err <= 1'b0;
         r_tv[0] <= w_dvalid;
         r_ts[0] <= w_sof;
         r_tl[0] <= w_last;
         for (int unsigned i = 1; i < LAT; i++) begin
            r_tv[i] <= r_tv[i-1];
            r_ts[i] <= r_ts[i-1];
            r_tl[i] <= r_tl[i-1];
         end
      end
   end

`ifdef FFT_FRAME_CTRL_ERRCNT_EN
   logic [7:0] r_err_cnt;
   logic       r_frm_ur;

   // r_frm_ur remembers an underrun earlier in the current frame; the frame is
   // counted once, on its N-1 cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= '0;
         r_frm_ur  <= 1'b0;
      end else begin
         if (w_last) begin
            r_frm_ur <= 1'b0;
         end else if (w_under) begin
            r_frm_ur <= 1'b1;
         end
         if (err_clr)
            r_err_cnt <= '0;
         else if (w_last && (r_frm_ur || w_under) && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err_cnt = r_err_cnt;
`endif

   assign in_ready  = w_ready & ~rst;
   assign cnt       = r_cnt;
   assign dvalid    = w_dvalid;
   assign din_sel   = w_dvalid;
   assign out_valid = r_tv[LAT-1];
   assign out_sof   = r_ts[LAT-1];
   assign out_last  = r_tl[LAT-1];
   assign busy      = (r_state != S_IDLE) | (|r_tv) | (|r_ts) | (|r_tl);
   assign err       = r_err;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
//   Directed bench for fft_frame_ctrl with N=8 (CBW=3), LAT=12. Inputs change
//   2 time units after the rising edge; outputs are sampled 1 unit later.

module tb_fft_frame_ctrl;

   logic       clk, rst, in_valid, err_clr;
   logic       in_ready, dvalid, din_sel, out_valid, out_sof, out_last, busy, err;
   logic [2:0] cnt;
`ifdef FFT_FRAME_CTRL_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   int npass = 0;
   int nfail = 0;
   int ntot  = 0;

   fft_frame_ctrl #(.CBW(3), .LAT(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cnt       (cnt),
      .dvalid    (dvalid),
      .din_sel   (din_sel),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err),
`ifdef FFT_FRAME_CTRL_ERRCNT_EN
      .err_cnt   (err_cnt),
`endif
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   // Runs nf frames from IDLE with an optional underrun gap at cycles glo..ghi,
   // then lets the sequencer flush back to IDLE. Cycle c is relative to the
   // first accepted sample. With LAT=12 and N=8 the sequencer is back in IDLE
   // at c = 8*nf+17.
   task automatic run_frames(input int nf, input int glo, input int ghi);
      for (int c = 0; c <= 8*nf + 19; c++) begin
         bit v, ov, gap_o;
         int co;
         next();
         v = (c < 8*nf) && !(c >= glo && c <= ghi);
         in_valid = v;
         #1;
         co    = c - 12;
         gap_o = (co >= glo && co <= ghi);
         ov    = (co >= 0) && (co < 8*nf) && !gap_o;
         chk("cnt", 32'(cnt), (c <= 8*nf + 16) ? 32'(c % 8) : 32'd0);
         chk("dvalid", 32'(dvalid), 32'(v));
         chk("din_sel", 32'(din_sel), 32'(v));
         chk("out_valid", 32'(out_valid), 32'(ov));
         chk("out_sof", 32'(out_sof), 32'((co >= 0) && (co < 8*nf) && (co % 8 == 0)));
         chk("out_last", 32'(out_last), 32'((co >= 0) && (co < 8*nf) && (co % 8 == 7)));
         chk("busy", 32'(busy), 32'((c >= 1) && (c <= 8*nf + 16)));
         chk("in_ready", 32'(in_ready), 32'((c <= 8*nf) || (c > 8*nf + 16) || (c % 8 == 0)));
         chk("err", 32'(err), 32'((glo < 999) && (c > glo)));
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 60; i++) begin
         next();
         in_valid = 1'b0;
         #1;
         if (!busy) break;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int hits;
      rst = 1'b1; in_valid = 1'b0; err_clr = 1'b0;

      // Reset
      next(); #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      next();
      next(); rst = 1'b0; #1;
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_dvalid", 32'(dvalid), 32'd0);
      chk("rst_din_sel", 32'(din_sel), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sof", 32'(out_sof), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_in_ready_idle", 32'(in_ready), 32'd1);

      // Single frame, flush, back to IDLE
      run_frames(1, 999, 999);
      // Three back-to-back frames
      run_frames(3, 999, 999);
      // Underrun at cnt 3,4
      run_frames(1, 3, 4);

      // err_clr against sticky err and against a same-cycle underrun
      next(); err_clr = 1'b1; #1;
      chk("err_before_clr", 32'(err), 32'd1);
      next(); err_clr = 1'b0; #1;
      chk("err_after_clr", 32'(err), 32'd0);
      next(); in_valid = 1'b1; #1;
      chk("t6_cnt0", 32'(cnt), 32'd0);
      next(); in_valid = 1'b0; err_clr = 1'b1; #1;
      chk("t6_underrun_dvalid", 32'(dvalid), 32'd0);
      next(); in_valid = 1'b1; err_clr = 1'b0; #1;
      chk("t6_err_set_wins", 32'(err), 32'd1);
      for (int c = 3; c < 8; c++) begin
         next(); in_valid = 1'b1; #1;
      end
      wait_idle("t6_idle");

      // New frame offered during FLUSH at cnt 5
      for (int c = 0; c <= 30; c++) begin
         next();
         in_valid = (c < 8) || (c >= 13 && c <= 23);
         #1;
         if (c >= 13 && c <= 15) begin
            chk("t4_cnt", 32'(cnt), 32'(c % 8));
            chk("t4_in_ready_blocked", 32'(in_ready), 32'd0);
            chk("t4_dvalid_blocked", 32'(dvalid), 32'd0);
         end
         if (c == 16) begin
            chk("t4_cnt_accept", 32'(cnt), 32'd0);
            chk("t4_in_ready_accept", 32'(in_ready), 32'd1);
            chk("t4_dvalid_accept", 32'(dvalid), 32'd1);
         end
         if (c == 17) begin
            chk("t4_run_cnt", 32'(cnt), 32'd1);
            chk("t4_run_ready", 32'(in_ready), 32'd1);
         end
         if (c >= 17) chk("t4_out_sof", 32'(out_sof), 32'(c == 28));
      end
      wait_idle("t4_idle");

      // Reset in the middle of a frame
      for (int c = 0; c <= 4; c++) begin
         next(); in_valid = 1'b1; rst = (c == 4); #1;
         chk("t5_cnt", 32'(cnt), 32'(c));
      end
      chk("t5_in_ready_rst", 32'(in_ready), 32'd0);
      next(); rst = 1'b0; in_valid = 1'b0; #1;
      chk("t5_cnt_after", 32'(cnt), 32'd0);
      chk("t5_busy_after", 32'(busy), 32'd0);
      chk("t5_dvalid_after", 32'(dvalid), 32'd0);
      chk("t5_out_valid_after", 32'(out_valid), 32'd0);
      chk("t5_in_ready_after", 32'(in_ready), 32'd1);
      hits = 0;
      for (int c = 0; c < 30; c++) begin
         next(); #1;
         if (out_sof || out_last || out_valid || busy) hits++;
      end
      chk("t5_no_stale_tokens", 32'(hits), 32'd0);

`ifdef FFT_FRAME_CTRL_ERRCNT_EN
      chk("ec_after_rst", 32'(err_cnt), 32'd0);
      for (int c = 0; c < 2400; c++) begin
         next(); in_valid = (c % 8) != 1; #1;
         if (c == 24) chk("ec_three", 32'(err_cnt), 32'd3);
         if (c == 2048) chk("ec_sat_256", 32'(err_cnt), 32'd255);
      end
      next(); in_valid = 1'b0; #1;
      chk("ec_300", 32'(err_cnt), 32'd255);
      wait_idle("ec_idle");
      next(); err_clr = 1'b1; #1;
      next(); err_clr = 1'b0; #1;
      chk("ec_cleared", 32'(err_cnt), 32'd0);
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
